// File: rtl/axis_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : axis_uart_tx
// Purpose  : AXI-Stream slave to UART transmitter (start, LSB-first data,
//            optional parity, 1 or 2 stop bits), bit = prescale*8 clk_sys.
// Revision : 1.0 - initial release
// ============================================================================
module axis_uart_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk_sys,
    input  logic                  async_rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [15:0]           prescale,
    output logic                  txd,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    localparam logic [3:0] c_DATA_LAST = 4'(DATA_WIDTH - 1);
    localparam logic [3:0] c_STOP_LAST = 4'(STOP_BITS - 1);

    generate
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("axis_uart_tx: PARITY must be 0, 1 or 2");
        end
        if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
            $error("axis_uart_tx: STOP_BITS must be 1 or 2");
        end
        if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
            $error("axis_uart_tx: DATA_WIDTH must be 5..9");
        end
    endgenerate

    state_t                state_q;
    logic [18:0]           period_q;
    logic [18:0]           timer_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [3:0]            bit_cnt_q;
    logic                  parity_q;
    logic                  txd_q;
    logic                  tready_q;
    logic                  busy_q;

    logic [15:0] w_prescale_eff;
    logic [18:0] w_period;
    logic        w_accept;
    logic        w_bit_end;

    assign w_prescale_eff = (prescale == 16'd0) ? 16'd1 : prescale;
    assign w_period       = {w_prescale_eff, 3'b000} - 19'd1;
    assign w_accept       = s_axis_tvalid && tready_q;
    assign w_bit_end      = (timer_q == 19'd0);

    always_ff @(posedge clk_sys or posedge async_rst) begin
        if (async_rst) begin
            state_q   <= S_IDLE;
            period_q  <= '0;
            timer_q   <= '0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            txd_q     <= 1'b1;
            tready_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            // txd follows the current state, so it lags the state by one edge
            case (state_q)
                S_START:  txd_q <= 1'b0;
                S_DATA:   txd_q <= shift_q[0];
                S_PARITY: txd_q <= parity_q;
                default:  txd_q <= 1'b1;
            endcase

            if (state_q != S_IDLE) begin
                timer_q <= w_bit_end ? period_q : timer_q - 19'd1;
            end

            case (state_q)
                S_IDLE: begin
                    if (w_accept) begin
                        shift_q   <= s_axis_tdata;
                        parity_q  <= (^s_axis_tdata) ^ (PARITY == 2);
                        period_q  <= w_period;
                        timer_q   <= w_period;
                        bit_cnt_q <= '0;
                        state_q   <= S_START;
                        tready_q  <= 1'b0;
                        busy_q    <= 1'b1;
                    end else begin
                        tready_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        shift_q <= shift_q >> 1;
                        if (bit_cnt_q == c_DATA_LAST) begin
                            bit_cnt_q <= '0;
                            state_q   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        if (bit_cnt_q == c_STOP_LAST) begin
                            bit_cnt_q <= '0;
                            state_q   <= S_IDLE;
                            busy_q    <= 1'b0;
                            tready_q  <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign s_axis_tready = tready_q;
    assign txd           = txd_q;
    assign busy          = busy_q;

endmodule
`default_nettype wire
